// File: rtl/pwm_pkg.sv
// Shared constants for the PWM DAC slice: sample width and reset-time period top.
package pwm_pkg;
  localparam int SAMPLE_W = 9;
  localparam logic [SAMPLE_W-1:0] PKG_DEFAULT_TOP = 9'd255;
endpackage

// File: rtl/pwm_period_counter.sv
// Free-running period counter: counts 0..top, wraps to 0; held at 0 while disabled.
module pwm_period_counter
  import pwm_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic [SAMPLE_W-1:0] i_top,
  output logic [SAMPLE_W-1:0] o_count,
  output logic                o_wrap
);

  logic [SAMPLE_W-1:0] count_q, count_d;

  always_comb begin
    o_wrap  = i_enable && (count_q == i_top);
    count_d = count_q + 1'b1;
    if (!i_enable || o_wrap) begin
      count_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/pwm_dac.sv
// PWM DAC: double-buffered compare/top registers applied at period wrap,
// registered PWM output with aligned period-start strobe.
module pwm_dac
  import pwm_pkg::*;
#(
  parameter logic [SAMPLE_W-1:0] DEFAULT_TOP = PKG_DEFAULT_TOP
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic [SAMPLE_W-1:0] i_compare,
  input  logic                i_compare_valid,
  input  logic [SAMPLE_W-1:0] i_top,
  input  logic                i_top_valid,
  output logic                o_pwm,
  output logic                o_period_start
);

  // Reset asserts immediately, releases two clocks later.
  logic rst_meta_q, rst_sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  logic                run_q, run_d;
  logic [SAMPLE_W-1:0] cmp_shadow_q, cmp_shadow_d;
  logic [SAMPLE_W-1:0] top_shadow_q, top_shadow_d;
  logic [SAMPLE_W-1:0] cmp_active_q, cmp_active_d;
  logic [SAMPLE_W-1:0] top_active_q, top_active_d;
  logic                pwm_q, pwm_d;
  logic                pstart_q, pstart_d;
  logic [SAMPLE_W-1:0] cmp_next, top_next, cmp_eff, top_eff;
  logic [SAMPLE_W-1:0] count;
  logic                wrap;

  // A strobe in the same cycle overrides the shadow (bypass); the first
  // enabled cycle uses the incoming shadow values as if a wrap just happened.
  always_comb begin
    cmp_next = i_compare_valid ? i_compare : cmp_shadow_q;
    top_next = i_top_valid     ? i_top     : top_shadow_q;
    cmp_eff  = run_q ? cmp_active_q : cmp_next;
    top_eff  = run_q ? top_active_q : top_next;
  end

  pwm_period_counter u_counter (
    .i_clk    (i_clk),
    .i_rst_n  (rst_sync_q),
    .i_enable (i_enable),
    .i_top    (top_eff),
    .o_count  (count),
    .o_wrap   (wrap)
  );

  always_comb begin
    run_d        = i_enable;
    cmp_shadow_d = cmp_next;
    top_shadow_d = top_next;
    cmp_active_d = cmp_active_q;
    top_active_d = top_active_q;
    if (i_enable) begin
      cmp_active_d = wrap ? cmp_next : cmp_eff;
      top_active_d = wrap ? top_next : top_eff;
    end
    // compare > top clamps to 100% naturally since count never exceeds top.
    pwm_d    = i_enable && (count < cmp_eff);
    pstart_d = i_enable && (count == '0);
  end

  always_ff @(posedge i_clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      run_q        <= 1'b0;
      cmp_shadow_q <= '0;
      top_shadow_q <= DEFAULT_TOP;
      cmp_active_q <= '0;
      top_active_q <= DEFAULT_TOP;
      pwm_q        <= 1'b0;
      pstart_q     <= 1'b0;
    end else begin
      run_q        <= run_d;
      cmp_shadow_q <= cmp_shadow_d;
      top_shadow_q <= top_shadow_d;
      cmp_active_q <= cmp_active_d;
      top_active_q <= top_active_d;
      pwm_q        <= pwm_d;
      pstart_q     <= pstart_d;
    end
  end

  assign o_pwm          = pwm_q;
  assign o_period_start = pstart_q;

endmodule

// File: tb/tb_pwm_dac.sv
// Bench for pwm_dac: directed scenarios plus randomized writes against a period-level model.
module tb_pwm_dac;

  logic       clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_enable = 1'b0;
  logic [8:0] i_compare = '0;
  logic       i_compare_valid = 1'b0;
  logic [8:0] i_top = '0;
  logic       i_top_valid = 1'b0;
  logic       o_pwm, o_period_start;

  pwm_dac #(.DEFAULT_TOP(9'd255)) dut (
    .i_clk           (clk),
    .i_rst_n         (i_rst_n),
    .i_enable        (i_enable),
    .i_compare       (i_compare),
    .i_compare_valid (i_compare_valid),
    .i_top           (i_top),
    .i_top_valid     (i_top_valid),
    .o_pwm           (o_pwm),
    .o_period_start  (o_period_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a period is described by (duty, top) captured at its
  // start; phase is the position inside the period seen by the next clock.
  bit m_in_rst = 1'b1;
  bit m_run    = 1'b0;
  int m_phase, m_duty, m_len_top, m_sh_c, m_sh_t;
  bit exp_pwm, exp_ps;

  task automatic model_reset();
    m_run = 0; m_phase = 0; m_duty = 0; m_len_top = 255;
    m_sh_c = 0; m_sh_t = 255; exp_pwm = 0; exp_ps = 0;
  endtask

  task automatic model_step(input bit en, input bit cv, input int c, input bit tv, input int t);
    if (m_in_rst) begin
      exp_pwm = 0; exp_ps = 0;
      return;
    end
    if (cv) m_sh_c = c;
    if (tv) m_sh_t = t;
    if (!en) begin
      m_run = 0; m_phase = 0; exp_pwm = 0; exp_ps = 0;
      return;
    end
    if (!m_run) begin
      m_run = 1; m_phase = 0; m_duty = m_sh_c; m_len_top = m_sh_t;
    end
    exp_pwm = (m_phase < m_duty);
    exp_ps  = (m_phase == 0);
    if (m_phase == m_len_top) begin
      m_phase = 0; m_duty = m_sh_c; m_len_top = m_sh_t;
    end else begin
      m_phase++;
    end
  endtask

  int hi_cnt, ps_cnt;

  task automatic cycle(input bit en, input bit cv, input int c, input bit tv, input int t);
    @(negedge clk);
    i_enable = en; i_compare_valid = cv; i_compare = c[8:0];
    i_top_valid = tv; i_top = t[8:0];
    @(posedge clk);
    model_step(en, cv, c, tv, t);
    #1;
    check_eq("pwm", int'(o_pwm), int'(exp_pwm));
    check_eq("pstart", int'(o_period_start), int'(exp_ps));
    hi_cnt += int'(o_pwm);
    ps_cnt += int'(o_period_start);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    i_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
    m_in_rst = 0;
  endtask

  initial begin
    bit found;
    model_reset();
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
    check_eq("rst_pwm", int'(o_pwm), 0);
    check_eq("rst_pstart", int'(o_period_start), 0);
    release_reset();

    // Default top 255, compare 64 written while idle.
    cycle(0, 1, 64, 0, 0);
    hi_cnt = 0; ps_cnt = 0;
    run(512);
    check_eq("duty64_highs", hi_cnt, 128);
    check_eq("duty64_starts", ps_cnt, 2);

    // Two writes inside one period: only the last one reaches the next period.
    run(20);
    cycle(1, 1, 200, 0, 0);
    run(30);
    cycle(1, 1, 10, 0, 0);
    run(600);

    // Write landing exactly on the wrap cycle.
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      if (m_run && m_phase == m_len_top) begin
        cycle(1, 1, 128, 0, 0);
        found = 1;
      end else begin
        run(1);
      end
    end
    check_eq("wrap_found", int'(found), 1);
    hi_cnt = 0; ps_cnt = 0;
    run(256);
    check_eq("bypass_highs", hi_cnt, 128);
    check_eq("bypass_starts", ps_cnt, 1);

    // top=3 with compare 0, 2, 4.
    cycle(1, 1, 0, 1, 3);
    run(300);
    hi_cnt = 0; ps_cnt = 0; run(16);
    check_eq("top3_c0_highs", hi_cnt, 0);
    check_eq("top3_starts", ps_cnt, 4);
    cycle(1, 1, 2, 0, 0); run(8);
    hi_cnt = 0; run(16);
    check_eq("top3_c2_highs", hi_cnt, 8);
    cycle(1, 1, 4, 0, 0); run(8);
    hi_cnt = 0; run(16);
    check_eq("top3_c4_highs", hi_cnt, 16);

    // top=0: every cycle is a period.
    cycle(1, 1, 1, 1, 0); run(6);
    hi_cnt = 0; ps_cnt = 0; run(10);
    check_eq("top0_highs", hi_cnt, 10);
    check_eq("top0_starts", ps_cnt, 10);
    cycle(1, 1, 0, 0, 0); run(2);
    hi_cnt = 0; run(10);
    check_eq("top0_c0_highs", hi_cnt, 0);

    // Randomized writes and enable toggling.
    for (int i = 0; i < 4000; i++) begin
      bit en, cv, tv;
      int c, t;
      en = ($urandom_range(0, 19) != 0);
      cv = ($urandom_range(0, 9) == 0);
      tv = ($urandom_range(0, 14) == 0);
      c  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 18);
      t  = ($urandom_range(0, 30) == 0) ? $urandom_range(0, 300) : $urandom_range(0, 15);
      cycle(en, cv, c, tv, t);
    end

    // Asynchronous reset in the middle of a long, high period.
    cycle(1, 1, 200, 1, 255);
    found = 0;
    for (int i = 0; i < 1200 && !found; i++) begin
      if (m_run && m_len_top == 255 && m_phase == 100) found = 1;
      else run(1);
    end
    check_eq("phase100_found", int'(found), 1);
    run(1);
    check_eq("pre_rst_pwm", int'(o_pwm), 1);
    @(negedge clk);
    i_rst_n = 1'b0;
    #1;
    check_eq("async_rst_pwm", int'(o_pwm), 0);
    check_eq("async_rst_pstart", int'(o_period_start), 0);
    m_in_rst = 1;
    model_reset();
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0, 0);
    release_reset();
    hi_cnt = 0; ps_cnt = 0;
    run(512);
    check_eq("post_rst_highs", hi_cnt, 0);
    check_eq("post_rst_starts", ps_cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
